// File: rtl/mem_bist_seq_pkg.sv
// Shared definitions for the dual-port memory test sequencer.
// The state encoding and the pattern-mode codes live here.
package mem_bist_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic MODE_NORM = 1'b0;
  localparam logic MODE_INV  = 1'b1;

endpackage

// File: rtl/mem_bist_seq_if.sv
// Bundle of the two RAM ports driven by the sequencer.
// master = sequencer side, slave = RAM side.
interface mem_bist_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] dataIn1;
  logic [DATA_W-1:0] dataIn2;
  logic              we1;
  logic              we2;
  logic [DATA_W-1:0] dataOut1;
  logic [DATA_W-1:0] dataOut2;

  modport master (
    output addr1, addr2, dataIn1, dataIn2, we1, we2,
    input  dataOut1, dataOut2
  );

  modport slave (
    input  addr1, addr2, dataIn1, dataIn2, we1, we2,
    output dataOut1, dataOut2
  );
endinterface

// File: rtl/mem_bist_seq_pattern_gen.sv
// Combinational test pattern: address XOR seed, optionally inverted.
// The address is zero-extended (or truncated) to the data width.
module mem_bist_seq_pattern_gen
  import mem_bist_seq_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter int          ADDR_W = 8,
  parameter int unsigned SEED   = 32'h0000_A5A5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              mode,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] raw;

  assign raw = DATA_W'(addr) ^ DATA_W'(SEED);

  always_comb begin
    pattern = raw;
    unique case (mode)
      MODE_NORM: pattern = raw;
      MODE_INV:  pattern = ~raw;
      default:   pattern = raw;
    endcase
  end

endmodule

// File: rtl/mem_bist_seq.sv
// Dual-port memory test sequencer: clear, write pattern, read back and compare.
// Port-1 walks even addresses, port-2 the odd neighbour, one pair per cycle.
module mem_bist_seq
  import mem_bist_seq_pkg::*;
#(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 8,
  parameter int          START_ADDR = 0,
  parameter int          END_ADDR   = 255,
  parameter int unsigned SEED       = 32'h0000_A5A5,
  parameter int          ERR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  mem_bist_seq_if.master    ram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int                P      = (END_ADDR - START_ADDR + 1) / 2;
  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(P - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(START_ADDR);

  state_t            state, state_n;
  logic [ADDR_W-1:0] p, p_n;
  logic              mode_r, mode_n;
  logic              active_n, wr_n, busy_n;
  logic [ADDR_W-1:0] addr1_n, addr2_n;
  logic [DATA_W-1:0] pat1_n, pat2_n;

  logic              vld_p1;
  logic [ADDR_W-1:0] exp_addr1_p1, exp_addr2_p1;
  logic [DATA_W-1:0] exp1_p1, exp2_p1;
  logic              cmp_en, mis1, mis2;
  logic [1:0]        inc;
  logic [ERR_W-1:0]  err_n;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [1:0]       b);
    logic [ERR_W:0] sum;
    sum = {1'b0, a} + (ERR_W+1)'(b);
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

  always_comb begin
    state_n = state;
    p_n     = p;
    mode_n  = mode_r;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_CLEAR;
          p_n     = '0;
          mode_n  = mode;
        end
      end
      S_CLEAR, S_WRITE, S_READ: begin
        if (abort) begin
          state_n = S_IDLE;
          p_n     = '0;
        end else if (p == P_LAST) begin
          p_n = '0;
          unique case (state)
            S_CLEAR: state_n = S_WRITE;
            S_WRITE: state_n = S_READ;
            default: state_n = S_DRAIN;
          endcase
        end else begin
          p_n = p + 1'b1;
        end
      end
      S_DRAIN: state_n = abort ? S_IDLE : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Port values for the coming cycle, derived from the next state and pair index
  assign active_n = (state_n == S_CLEAR) || (state_n == S_WRITE) || (state_n == S_READ);
  assign wr_n     = (state_n == S_CLEAR) || (state_n == S_WRITE);
  assign busy_n   = active_n || (state_n == S_DRAIN);
  assign addr1_n  = active_n ? BASE + (p_n << 1) : '0;
  assign addr2_n  = active_n ? addr1_n + ADDR_W'(1) : '0;

  mem_bist_seq_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_pat_wr1 (
    .addr(addr1_n), .mode(mode_n), .pattern(pat1_n)
  );
  mem_bist_seq_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_pat_wr2 (
    .addr(addr2_n), .mode(mode_n), .pattern(pat2_n)
  );

  // ---- stage p1: address of the read in flight, aligned with RAM read data
  always_ff @(posedge clk) begin
    exp_addr1_p1 <= ram.addr1;
    exp_addr2_p1 <= ram.addr2;
  end

  mem_bist_seq_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_pat_exp1 (
    .addr(exp_addr1_p1), .mode(mode_r), .pattern(exp1_p1)
  );
  mem_bist_seq_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_pat_exp2 (
    .addr(exp_addr2_p1), .mode(mode_r), .pattern(exp2_p1)
  );

  // Gate on state so an abort discards the read still in flight
  assign cmp_en = vld_p1 && ((state == S_READ) || (state == S_DRAIN));
  assign mis1   = cmp_en && (ram.dataOut1 != exp1_p1);
  assign mis2   = cmp_en && (ram.dataOut2 != exp2_p1);
  assign inc    = {1'b0, mis1} + {1'b0, mis2};
  assign err_n  = sat_add(err_count, inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      p           <= '0;
      mode_r      <= 1'b0;
      vld_p1      <= 1'b0;
      ram.addr1   <= '0;
      ram.addr2   <= '0;
      ram.dataIn1 <= '0;
      ram.dataIn2 <= '0;
      ram.we1     <= 1'b0;
      ram.we2     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_addr   <= '0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      mode_r      <= mode_n;
      vld_p1      <= (state == S_READ);
      ram.addr1   <= addr1_n;
      ram.addr2   <= addr2_n;
      ram.dataIn1 <= (state_n == S_WRITE) ? pat1_n : '0;
      ram.dataIn2 <= (state_n == S_WRITE) ? pat2_n : '0;
      ram.we1     <= wr_n;
      ram.we2     <= wr_n;
      busy        <= busy_n;
      done        <= (state_n == S_DONE);
      if ((state == S_IDLE) && (state_n == S_CLEAR)) begin
        err_count <= '0;
        fail_addr <= '0;
        pass      <= 1'b0;
      end else begin
        if (cmp_en) begin
          err_count <= err_n;
          // Only the first failing pair is recorded; port 1 holds the lower address
          if ((err_count == '0) && (mis1 || mis2))
            fail_addr <= mis1 ? exp_addr1_p1 : exp_addr2_p1;
        end
        if (state_n == S_DONE)
          pass <= (err_n == '0);
        else if ((state != S_IDLE) && (state != S_DONE) && (state_n == S_IDLE))
          pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_seq.sv
// Directed bench for mem_bist_seq over an 8-word range with a 1-cycle RAM model.
// Table-driven full runs plus hand-written abort, ignore and async-reset sequences.
module tb_mem_bist_seq;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode  = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_addr;

  mem_bist_seq_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  mem_bist_seq #(
    .DATA_W(16), .ADDR_W(8), .START_ADDR(0), .END_ADDR(7),
    .SEED(32'h0000_A5A5), .ERR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .ram(bus), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  // Registered-read RAM; flip[] corrupts read data to plant faults
  logic [15:0] mem  [0:255];
  logic [15:0] flip [0:255];
  always @(posedge clk) begin
    if (bus.we1) mem[bus.addr1] <= bus.dataIn1;
    if (bus.we2) mem[bus.addr2] <= bus.dataIn2;
    bus.dataOut1 <= mem[bus.addr1] ^ flip[bus.addr1];
    bus.dataOut2 <= mem[bus.addr2] ^ flip[bus.addr2];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic clear_flip();
    for (int i = 0; i < 256; i++) flip[i] = 16'h0000;
  endtask

  typedef struct {
    logic        mode;
    int          fa;
    logic [15:0] fm_a;
    int          fb;
    logic [15:0] fm_b;
    logic [15:0] wd1;   // port-2 write data at addr 1
    logic [15:0] wd5;   // port-2 write data at addr 5
    logic        pass;
    logic [7:0]  err;
    logic [7:0]  fail;
  } vec_t;

  vec_t vecs [5];

  task automatic run_test(input vec_t v, input string tag);
    int   n;
    logic busy_drain;
    n = -1;
    busy_drain = 1'b0;
    clear_flip();
    if (v.fa >= 0) flip[v.fa] = v.fm_a;
    if (v.fb >= 0) flip[v.fb] = v.fm_b;
    @(negedge clk);
    start = 1'b1;
    mode  = v.mode;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'b0;
    check({tag, "_busy_first"}, 64'(busy), 64'd1);
    for (int i = 1; i <= 30 && n < 0; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        check({tag, "_wr_addr2_p0"}, 64'(bus.addr2), 64'd1);
        check({tag, "_wr_data_a1"}, 64'(bus.dataIn2), 64'(v.wd1));
      end
      if (i == 6) begin
        check({tag, "_wr_we2_p2"}, 64'(bus.we2), 64'd1);
        check({tag, "_wr_data_a5"}, 64'(bus.dataIn2), 64'(v.wd5));
      end
      if (i == 12) busy_drain = busy;
      if (done) n = i;
    end
    check({tag, "_done_latency"}, 64'(n), 64'd13);
    check({tag, "_busy_drain"}, 64'(busy_drain), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'(v.pass));
    check({tag, "_err_count"}, 64'(err_count), 64'(v.err));
    check({tag, "_fail_addr"}, 64'(fail_addr), 64'(v.fail));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_pass_held"}, 64'(pass), 64'(v.pass));
  endtask

  initial begin
    int dn;
    vecs[0] = '{1'b0, -1, 16'h0000, -1, 16'h0000, 16'hA5A4, 16'hA5A0, 1'b1, 8'd0, 8'd0};
    vecs[1] = '{1'b0,  5, 16'h0008, -1, 16'h0000, 16'hA5A4, 16'hA5A0, 1'b0, 8'd1, 8'd5};
    vecs[2] = '{1'b0,  2, 16'h0001,  3, 16'h8000, 16'hA5A4, 16'hA5A0, 1'b0, 8'd2, 8'd2};
    vecs[3] = '{1'b1, -1, 16'h0000, -1, 16'h0000, 16'h5A5B, 16'h5A5F, 1'b1, 8'd0, 8'd0};
    vecs[4] = '{1'b1,  7, 16'hFFFF,  4, 16'h0100, 16'h5A5B, 16'h5A5F, 1'b0, 8'd2, 8'd4};
    clear_flip();

    #2 reset = 1'b0;
    #1;
    check("reset_ports", {bus.addr1, bus.addr2, bus.dataIn1, bus.dataIn2}, 64'd0);
    check("reset_status", {bus.we1, bus.we2, busy, done, pass, err_count, fail_addr}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_we", {bus.we1, bus.we2}, 64'd0);

    for (int t = 0; t < 5; t++) run_test(vecs[t], $sformatf("vec%0d", t));

    // Restart mid-WRITE is ignored; abort mid-READ keeps partial results
    clear_flip();
    flip[1] = 16'h0004;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b1;
      if (i == 6) begin
        start = 1'b0;
        check("ignore_addr1", 64'(bus.addr1), 64'd4);
        check("ignore_data1", 64'(bus.dataIn1), 64'hA5A1);
      end
      if (i == 10) abort = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_we", {bus.we1, bus.we2}, 64'd0);
    check("abort_pass", 64'(pass), 64'd0);
    check("abort_err_count", 64'(err_count), 64'd1);
    check("abort_fail_addr", 64'(fail_addr), 64'd1);
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    // Asynchronous reset between edges during CLEAR
    clear_flip();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    check("clear_we_active", {bus.we1, bus.we2, busy}, 64'h7);
    reset = 1'b0;
    #1;
    check("async_rst_ports", {bus.addr1, bus.addr2, bus.dataIn1, bus.dataIn2}, 64'd0);
    check("async_rst_status", {bus.we1, bus.we2, busy, done, pass, err_count, fail_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_test(vecs[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
